aes_dec_iter: RTL and testbench
===============================

Name: aes_dec_iter

Overview:
- Iterative AES-128 decryption core; the inverse of the team's unrolled combinational encryptor.
- One round per clock; a single round datapath is reused across all rounds.
- Holds the expanded round-key schedule (rk0..rk10) internally, so consecutive blocks under the same key skip expansion.
- Sits between the cipher-input interface and the plaintext consumer, with a start/done handshake.

Parameters:
- None. AES-128 only: 10 rounds, 128-bit key, 128-bit block, all fixed.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted on a clk edge where start=1 and ready=1.
- new_key  input  1  sampled with start. 1 = expand key; 0 = reuse stored schedule.
- key  input  [0:127]  cipher key, sampled on the accepting edge when expansion runs.
- data  input  [0:127]  ciphertext, sampled on the accepting edge.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse when de_data becomes valid.
- de_data  output  [0:127]  plaintext; held until the next accepted start.
- key_valid  output  1  high once a full schedule is stored.

Behaviour:
- Byte order is FIPS-197: bits [0:7] = byte 0, column-major state. Vectors are written with bit 0 as MSB.
- Reset (synchronous, rst=1 at edge): state=IDLE, ready=1, done=0, de_data=0, key_valid=0, round counter=0. The schedule storage contents are don't-care.
- rst takes priority over everything. Reset mid-operation aborts the block: no done pulse, key_valid=0.
- FSM states and transitions:
  - IDLE: on accept, latch data.
    - If new_key=1, or key_valid=0: go to KEXP, latch key into rk0, clear key_valid. new_key=0 with key_valid=0 is forced to expansion.
    - Otherwise go to ADD0.
  - KEXP: 10 cycles (counter 1..10). Each cycle computes rk[i] from rk[i-1] with RotWord/SubWord/Rcon. Rcon = 01,02,04,08,10,20,40,80,1b,36 in the top byte. key_valid is set on the 10th cycle. Then go to ADD0.
  - ADD0: 1 cycle. state <= ct ^ rk10. Go to RND with r=9.
  - RND: 9 cycles, r=9 down to 1. state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]). After r=1, go to FIN.
  - FIN: 1 cycle. de_data <= InvSubBytes(InvShiftRows(state)) ^ rk0. done <= 1. Go to IDLE.
- Latency, with accepting edge = E:
  - new_key path: done high after edge E+21.
  - Reuse path: done high after edge E+11.
  - ready returns to 1 in the same cycle done is high. Back-to-back start is therefore allowed while done=1.
- start while ready=0 is ignored. No queuing; inputs are not sampled.
- de_data changes only on the FIN edge. It stays stable between done pulses and is not cleared on a new start.
- done is never high for more than one consecutive cycle.
- key and data may change freely after the accepting edge; the core uses only latched copies.
- Helper blocks: the inverse S-box, InvShiftRows and InvMixColumns are purely combinational sibling blocks, specified separately. The forward S-box is needed for SubWord in key expansion. All registers are reset-qualified as listed; the datapath has no other state.

Test Plan:
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, data=69c4e0d86a7b0430d8cdb78070b4c55a, new_key=1 -> done after edge E+21, de_data=00112233445566778899aabbccddeeff, key_valid=1.
- FIPS-197 App. B: key=2b7e151628aed2a6abf7158809cf4f3c, data=3925841d02dc09fbdc118597196a0b32 -> de_data=3243f6a8885a308d313198a2e0370734. Also check intermediate state after ADD0 equals ct^rk10, with rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Key reuse: after the App. B run, assert start with new_key=0 and the same ct, key input driven to all-ones -> done after edge E+11, identical plaintext. Then back-to-back start in the done cycle -> accepted.
- Forced expansion: immediately after reset, start with new_key=0 and C.1 inputs -> takes the 21-cycle path, correct plaintext.
- Busy-ignore: pulse start with garbage data at cycles E+3 and E+15 of a C.1 run -> result unchanged, exactly one done pulse.
- Reset mid-op: assert rst at E+8 (KEXP) and, in a separate run, at E+17 (RND) -> next cycle ready=1, done=0, key_valid=0, de_data=0. A following C.1 run is correct.

Source files
------------

// File: rtl/aes_dec_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes_dec_iter
// Brief    : Iterative AES-128 decryptor, one inverse round per clock, with a
//            stored round-key schedule reused across blocks under one key.
// Revision : 1.0 - initial release
// ============================================================================
module aes_dec_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         new_key,
  input  logic [0:127] key,
  input  logic [0:127] data,
  output logic         ready,
  output logic         done,
  output logic [0:127] de_data,
  output logic         key_valid
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_KEXP = 3'd1,
    S_ADD0 = 3'd2,
    S_RND  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [0:255][7:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // The inverse S-box is derived from the forward table at elaboration time.
  function automatic logic [0:255][7:0] f_inv_table(input logic [0:255][7:0] t);
    logic [0:255][7:0] inv;
    inv = '0;
    for (int i = 0; i < 256; i++) inv[t[i]] = 8'(i);
    return inv;
  endfunction

  localparam logic [0:255][7:0] C_INV_SBOX = f_inv_table(C_SBOX);

  function automatic logic [7:0] f_xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] f_gmul(input logic [7:0] x, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = f_xtime(x);
    x4 = f_xtime(x2);
    x8 = f_xtime(x4);
    return (c[0] ? x : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  // Byte (r + 4c) of the result comes from column (c - r) mod 4 of row r.
  function automatic logic [0:127] f_inv_sr_sb(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(r + 4*c) +: 8] = C_INV_SBOX[s[8*(r + 4*((c - r) & 3)) +: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] f_inv_mix(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c      +: 8] = f_gmul(a0, 4'he) ^ f_gmul(a1, 4'hb) ^ f_gmul(a2, 4'hd) ^ f_gmul(a3, 4'h9);
      o[32*c + 8  +: 8] = f_gmul(a0, 4'h9) ^ f_gmul(a1, 4'he) ^ f_gmul(a2, 4'hb) ^ f_gmul(a3, 4'hd);
      o[32*c + 16 +: 8] = f_gmul(a0, 4'hd) ^ f_gmul(a1, 4'h9) ^ f_gmul(a2, 4'he) ^ f_gmul(a3, 4'hb);
      o[32*c + 24 +: 8] = f_gmul(a0, 4'hb) ^ f_gmul(a1, 4'hd) ^ f_gmul(a2, 4'h9) ^ f_gmul(a3, 4'he);
    end
    return o;
  endfunction

  function automatic logic [0:127] f_key_step(input logic [0:127] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[0:31];
    w1 = k[32:63];
    w2 = k[64:95];
    w3 = k[96:127];
    t  = {C_SBOX[w3[23:16]], C_SBOX[w3[15:8]], C_SBOX[w3[7:0]], C_SBOX[w3[31:24]]} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t       r_fsm;
  logic [3:0]   r_cnt;
  logic         r_ready;
  logic         r_done;
  logic         r_kv;
  logic [0:127] r_blk;
  logic [0:127] r_de;
  logic [0:127] r_kw;
  logic [0:127] r_rk [0:10];

  logic         w_accept;
  logic         w_expand;
  logic [7:0]   w_rcon;
  logic [0:127] w_kw_next;
  logic [0:127] w_rk_sel;
  logic [0:127] w_inv_sr_sb;

  assign w_accept    = start & r_ready;
  assign w_expand    = new_key | ~r_kv;
  assign w_kw_next   = f_key_step(r_kw, w_rcon);
  // The round counter doubles as the schedule index: 10 in ADD0, r in RND, 0 in FIN.
  assign w_rk_sel    = (r_cnt <= 4'd10) ? r_rk[r_cnt] : '0;
  assign w_inv_sr_sb = f_inv_sr_sb(r_blk);

  always_comb begin
    w_rcon = 8'h00;
    case (r_cnt)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_accept && w_expand) begin
        r_kw     <= key;
        r_rk[0]  <= key;
      end else if (r_fsm == S_KEXP) begin
        r_kw         <= w_kw_next;
        r_rk[r_cnt]  <= w_kw_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm   <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_kv    <= 1'b0;
      r_blk   <= '0;
      r_de    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          if (w_accept) begin
            r_blk   <= data;
            r_ready <= 1'b0;
            if (w_expand) begin
              r_fsm <= S_KEXP;
              r_kv  <= 1'b0;
              r_cnt <= 4'd1;
            end else begin
              r_fsm <= S_ADD0;
              r_cnt <= 4'd10;
            end
          end
        end
        S_KEXP: begin
          if (r_cnt == 4'd10) begin
            r_kv  <= 1'b1;
            r_fsm <= S_ADD0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_ADD0: begin
          r_blk <= r_blk ^ w_rk_sel;
          r_cnt <= 4'd9;
          r_fsm <= S_RND;
        end
        S_RND: begin
          r_blk <= f_inv_mix(w_inv_sr_sb ^ w_rk_sel);
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_fsm <= S_FIN;
        end
        S_FIN: begin
          r_de    <= w_inv_sr_sb ^ w_rk_sel;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_cnt   <= 4'd0;
          r_fsm   <= S_IDLE;
        end
        default: begin
          r_fsm   <= S_IDLE;
          r_ready <= 1'b1;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign done      = r_done;
  assign de_data   = r_de;
  assign key_valid = r_kv;

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_dec_iter
// Brief    : Scoreboard bench for aes_dec_iter using FIPS-197 vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_dec_iter;

  localparam logic [0:127] C_C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] C_C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] C_C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C_B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] C_B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] C_B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] C_B_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rst, start, new_key;
  logic [0:127] key, data;
  logic         ready, done, key_valid;
  logic [0:127] de_data;

  aes_dec_iter dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .new_key   (new_key),
    .key       (key),
    .data      (data),
    .ready     (ready),
    .done      (done),
    .de_data   (de_data),
    .key_valid (key_valid)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [0:127] pt;
    int           due;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   cyc    = 0;
  int   n_done = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Done monitor: pops the scoreboard and checks plaintext and latency.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && done) begin
      n_done++;
      chk("done_single_cycle", prev_done, 1'b0);
      if (q.size() == 0) begin
        chk("spurious_done", 1'b1, 1'b0);
      end else begin
        e = q.pop_front();
        chk("plaintext", de_data, e.pt);
        chk("latency_edge", cyc, e.due);
      end
    end
    prev_done = done;
  end

  // Caller is at a negedge; the following posedge is the accepting edge.
  task automatic start_op(input logic [0:127] k, input logic [0:127] ct, input logic nk,
                          input logic [0:127] pt, input int lat, output int e_edge);
    exp_t e;
    chk("ready_before_start", ready, 1'b1);
    start   = 1'b1;
    new_key = nk;
    key     = k;
    data    = ct;
    @(posedge clk);
    #1;
    e_edge = cyc;
    e.pt   = pt;
    e.due  = cyc + lat;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    key   = {$urandom, $urandom, $urandom, $urandom};
    data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    chk("done_within_budget", done, 1'b1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"},     ready,     1'b1);
    chk({tag, "_done"},      done,      1'b0);
    chk({tag, "_key_valid"}, key_valid, 1'b0);
    chk({tag, "_de_data"},   de_data,   128'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int d0;
    rst = 1'b1; start = 1'b0; new_key = 1'b0; key = '0; data = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    @(negedge clk);

    // No schedule stored yet: new_key=0 must still take the expansion path.
    start_op(C_C1_KEY, C_C1_CT, 1'b0, C_C1_PT, 21, e);
    wait_done(40);
    chk("kv_after_forced", key_valid, 1'b1);
    @(negedge clk);

    // C.1 with new key, start pulses while busy at E+3 and E+15.
    d0 = n_done;
    start_op(C_C1_KEY, C_C1_CT, 1'b1, C_C1_PT, 21, e);
    for (int i = 0; i < 40 && !done; i++) begin
      if (cyc == e + 2 || cyc == e + 14) begin
        start   = 1'b1;
        new_key = 1'b1;
        key     = {$urandom, $urandom, $urandom, $urandom};
        data    = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_run_done", done, 1'b1);
    repeat (3) @(negedge clk);
    chk("busy_one_done", n_done - d0, 1);

    // App. B with intermediate check after ADD0.
    start_op(C_B_KEY, C_B_CT, 1'b1, C_B_PT, 21, e);
    while (cyc < e + 11) @(negedge clk);
    chk("add0_state", dut.r_blk, C_B_CT ^ C_B_RK10);
    wait_done(30);
    @(negedge clk);

    // Reuse stored schedule, key input all ones, then back-to-back in done cycle.
    start_op('1, C_B_CT, 1'b0, C_B_PT, 11, e);
    wait_done(20);
    start_op('1, C_B_CT, 1'b0, C_B_PT, 11, e);
    wait_done(20);
    chk("kv_after_reuse", key_valid, 1'b1);
    repeat (2) @(negedge clk);

    // Reset during key expansion (edge E+8).
    start_op(C_C1_KEY, C_C1_CT, 1'b1, C_C1_PT, 21, e);
    while (cyc < e + 7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_kexp");
    q.delete();
    rst = 1'b0;
    repeat (25) @(negedge clk);

    start_op(C_C1_KEY, C_C1_CT, 1'b1, C_C1_PT, 21, e);
    wait_done(40);
    @(negedge clk);

    // Reset during the inverse rounds (edge E+17).
    start_op(C_B_KEY, C_B_CT, 1'b1, C_B_PT, 21, e);
    while (cyc < e + 16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_rnd");
    q.delete();
    rst = 1'b0;
    repeat (25) @(negedge clk);

    // Schedule was invalidated by reset, so this must expand again.
    start_op(C_C1_KEY, C_C1_CT, 1'b0, C_C1_PT, 21, e);
    wait_done(40);
    chk("kv_final", key_valid, 1'b1);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
